// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the PCPU MEM stage and a host debug/loader port.
// The CPU owns the RAM by default; the host gets bounded bursts once the pipeline has drained.
module dmem_arbiter #(
  parameter int DRAIN_CYCLES   = 2,
  parameter int MAX_BURST      = 16,
  parameter int MIN_CPU_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_running,
  input  logic [7:0]  cpu_d_addr,
  input  logic [15:0] cpu_d_dataout,
  input  logic        cpu_d_we,
  output logic [15:0] cpu_d_datain,
  output logic        cpu_hold,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_gnt,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_CPU,
    ST_DRAIN,
    ST_HOST,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] GUARD_INIT = 8'(MIN_CPU_CYCLES);

  state_t     state;
  logic [7:0] drain_cnt;
  logic [7:0] burst_cnt;
  logic [7:0] guard_cnt;

  // A host access coinciding with reset is dropped, so ack and the write are gated.
  assign host_ack     = host_gnt & host_req & ~reset;
  assign cpu_d_datain = mem_rdata;

  always_comb begin
    mem_addr  = cpu_d_addr;
    mem_wdata = cpu_d_dataout;
    mem_we    = cpu_d_we & (state != ST_RELEASE);
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_ack & host_we;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_CPU;
      cpu_hold    <= 1'b0;
      host_gnt    <= 1'b0;
      drain_cnt   <= '0;
      burst_cnt   <= '0;
      guard_cnt   <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_ack & ~host_we;
      if (host_ack && !host_we) begin
        host_rdata <= mem_rdata;
      end

      unique case (state)
        ST_CPU: begin
          if (guard_cnt != 8'd0) begin
            guard_cnt <= guard_cnt - 8'd1;
          end else if (host_req) begin
            cpu_hold <= 1'b1;
            if (cpu_running) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              state    <= ST_HOST;
              host_gnt <= 1'b1;
            end
          end
        end

        // Drain runs to completion even if the CPU stops mid-way.
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 8'd1;
          if (!host_req) begin
            state <= ST_RELEASE;
          end else if (drain_cnt == DRAIN_LAST) begin
            state    <= ST_HOST;
            host_gnt <= 1'b1;
          end
        end

        ST_HOST: begin
          if (!host_req) begin
            state    <= ST_RELEASE;
            host_gnt <= 1'b0;
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
            if (burst_cnt == BURST_LAST) begin
              state    <= ST_RELEASE;
              host_gnt <= 1'b0;
            end
          end
        end

        ST_RELEASE: begin
          state     <= ST_CPU;
          cpu_hold  <= 1'b0;
          guard_cnt <= GUARD_INIT;
          burst_cnt <= '0;
        end

        default: state <= ST_CPU;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter, checked cycle by cycle against an
// ownership model built from countdown timers plus a reference copy of the RAM.
module tb_dmem_arbiter;

  localparam int DRAIN = 2;
  localparam int MAXB  = 16;
  localparam int MINC  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_running;
  logic [7:0]  cpu_d_addr;
  logic [15:0] cpu_d_dataout;
  logic        cpu_d_we;
  logic [15:0] cpu_d_datain;
  logic        cpu_hold;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  dmem_arbiter #(
    .DRAIN_CYCLES  (DRAIN),
    .MAX_BURST     (MAXB),
    .MIN_CPU_CYCLES(MINC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_running  (cpu_running),
    .cpu_d_addr   (cpu_d_addr),
    .cpu_d_dataout(cpu_d_dataout),
    .cpu_d_we     (cpu_d_we),
    .cpu_d_datain (cpu_d_datain),
    .cpu_hold     (cpu_hold),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_ack     (host_ack),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'((i * 40503) ^ 23130);
  endfunction

  // Bench-side single-port RAM with combinational read
  logic        load_ram;
  logic [15:0] ram [256];
  assign mem_rdata = ram[mem_addr];

  always @(posedge clock) begin
    if (load_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  int total = 0;
  int bad = 0;
  int dut_acks = 0;

  // Ownership model: hold/grant flags, a drain countdown, a release flag and a guard countdown
  logic        m_hold, m_gnt, m_release, m_rvalid, m_last_ack;
  int          m_drain_left, m_guard, m_acks;
  logic [15:0] m_rdata;
  logic [15:0] ref_mem [256];
  logic        cpu_pattern;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic modelReset();
    m_hold = 0; m_gnt = 0; m_release = 0; m_rvalid = 0; m_last_ack = 0;
    m_drain_left = 0; m_guard = 0; m_acks = 0; m_rdata = '0;
  endtask

  task automatic applyStimulus(input logic rst, input logic hreq, input logic hwe,
                               input logic [7:0] haddr, input logic [15:0] hdata);
    reset      = rst;
    host_req   = hreq;
    host_we    = hwe;
    host_addr  = haddr;
    host_wdata = hdata;
    if (cpu_pattern) begin
      cpu_d_we      = 1'b1;
      cpu_d_addr    = 8'h20;
      cpu_d_dataout = 16'h1234;
    end else begin
      cpu_d_we      = 1'($urandom_range(0, 1));
      cpu_d_addr    = 8'h80 | 8'($urandom_range(0, 127));
      cpu_d_dataout = 16'($urandom);
    end
  endtask

  // Check this cycle's outputs, advance the model by one clock, land at posedge+1
  task automatic stepCycle();
    logic        e_ack, e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;
    #3;
    e_ack = m_gnt && host_req && !reset;
    if (m_gnt) begin
      e_addr = host_addr; e_wdata = host_wdata; e_we = e_ack && host_we;
    end else begin
      e_addr = cpu_d_addr; e_wdata = cpu_d_dataout; e_we = cpu_d_we && !m_release;
    end
    checkOutput("cpu_hold", 32'(cpu_hold), 32'(m_hold));
    checkOutput("host_gnt", 32'(host_gnt), 32'(m_gnt));
    checkOutput("host_ack", 32'(host_ack), 32'(e_ack));
    checkOutput("host_rvalid", 32'(host_rvalid), 32'(m_rvalid));
    checkOutput("host_rdata", 32'(host_rdata), 32'(m_rdata));
    checkOutput("mem_we", 32'(mem_we), 32'(e_we));
    checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
    checkOutput("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    checkOutput("cpu_d_datain", 32'(cpu_d_datain), 32'(ref_mem[e_addr]));
    if (host_ack === 1'b1) dut_acks++;
    m_last_ack = e_ack;

    if (reset) begin
      modelReset();
    end else begin
      m_rvalid = e_ack && !host_we;
      if (m_rvalid) m_rdata = ref_mem[host_addr];
      if (m_gnt) begin
        if (host_req) m_acks++;
        if (!host_req || m_acks == MAXB) begin
          m_gnt = 0; m_release = 1;
        end
      end else if (m_release) begin
        m_release = 0; m_hold = 0; m_guard = MINC; m_acks = 0;
      end else if (m_hold) begin
        if (!host_req) begin
          m_drain_left = 0; m_release = 1;
        end else begin
          m_drain_left--;
          if (m_drain_left == 0) m_gnt = 1;
        end
      end else if (m_guard > 0) begin
        m_guard--;
      end else if (host_req) begin
        m_hold = 1;
        if (cpu_running) m_drain_left = DRAIN;
        else m_gnt = 1;
      end
    end
    if (e_we) ref_mem[e_addr] = e_wdata;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      stepCycle();
    end
  endtask

  logic        done, r_req, r_we, rst_r;
  logic [7:0]  r_addr;
  logic [15:0] r_data, t5_old;
  int          idx;

  initial begin
    cpu_pattern = 0; cpu_running = 0; load_ram = 1; reset = 1;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    cpu_d_we = 0; cpu_d_addr = '0; cpu_d_dataout = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (2) @(posedge clock);
    #1;
    load_ram = 0;
    modelReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    stepCycle();
    idle(2);

    $display("[TB] running CPU, host read of 0x10");
    cpu_running = 1; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
      stepCycle();
      if (m_last_ack) done = 1;
    end
    checkOutput("t1_acked", 32'(done), 32'd1);
    idle(1);
    checkOutput("t1_rdata", 32'(host_rdata), 32'hBEEF);
    idle(4);

    $display("[TB] 20-word host write burst");
    dut_acks = 0; idx = 0;
    for (int k = 0; k < 120 && idx < 20; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(idx), 16'hA000 + 16'(idx));
      stepCycle();
      if (m_last_ack) idx++;
    end
    idle(4);
    checkOutput("t2_acks", 32'(dut_acks), 32'd20);
    for (int i = 0; i < 20; i++) checkOutput("t2_ram", 32'(ram[i]), 32'hA000 + 32'(i));

    $display("[TB] CPU and host writing concurrently");
    cpu_pattern = 1;
    for (int r = 0; r < 3; r++) begin
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h21, 16'h5555);
        stepCycle();
        if (m_last_ack) done = 1;
      end
      checkOutput("t3_acked", 32'(done), 32'd1);
      idle(8);
    end
    cpu_pattern = 0;
    checkOutput("t3_ram20", 32'(ram[32]), 32'h1234);
    checkOutput("t3_ram21", 32'(ram[33]), 32'h5555);

    $display("[TB] idle CPU, immediate grant");
    cpu_running = 0;
    idle(8);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000);
    stepCycle();
    checkOutput("t4_gnt_next", 32'(host_gnt), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000);
    stepCycle();
    idle(4);

    $display("[TB] reset in the middle of a burst");
    cpu_running = 1; idx = 0;
    idle(8);
    for (int k = 0; k < 40 && idx < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h40 + 8'(idx), 16'hC000 + 16'(idx));
      stepCycle();
      if (m_last_ack) idx++;
    end
    t5_old = ref_mem[67];
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h43, 16'hC003);
    stepCycle();
    checkOutput("t5_gnt", 32'(host_gnt), 32'd0);
    checkOutput("t5_hold", 32'(cpu_hold), 32'd0);
    idle(2);
    checkOutput("t5_lost_write", 32'(ram[67]), 32'(t5_old));

    $display("[TB] request dropped during drain");
    idle(8);
    dut_acks = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h30, 16'h0000);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h30, 16'h0000);
    stepCycle();
    checkOutput("t6_release_hold", 32'(cpu_hold), 32'd1);
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h30, 16'h0000);
      stepCycle();
      if (m_last_ack) done = 1;
    end
    checkOutput("t6_acks", 32'(dut_acks), 32'd1);
    idle(4);

    $display("[TB] randomized traffic");
    r_req = 0; r_we = 0; r_addr = '0; r_data = '0;
    for (int c = 0; c < 1500; c++) begin
      if (r_req && m_last_ack) begin
        if ($urandom_range(0, 3) != 0) begin
          r_we = 1'($urandom_range(0, 1)); r_addr = 8'($urandom_range(0, 127)); r_data = 16'($urandom);
        end else begin
          r_req = 0;
        end
      end else if (!r_req && $urandom_range(0, 3) == 0) begin
        r_req = 1;
        r_we = 1'($urandom_range(0, 1)); r_addr = 8'($urandom_range(0, 127)); r_data = 16'($urandom);
      end else if (r_req && $urandom_range(0, 49) == 0) begin
        r_req = 0;
      end
      if ($urandom_range(0, 99) == 0) cpu_running = ~cpu_running;
      rst_r = ($urandom_range(0, 299) == 0);
      applyStimulus(rst_r, r_req, r_we, r_addr, r_data);
      stepCycle();
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
